// File: rtl/instruction_execute.sv
// EX stage: operand selection, ALU, branch resolution and the EX/MEM pipeline register.
// Branch decision and target are combinational; every other output is registered.
module instruction_execute #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_re_in,
    input  logic            mem_we_in,
    input  logic            reg_file_write_in,
    input  logic            branch_instruction_in,
    input  logic [1:0]      alu_op_in,
    input  logic [1:0]      select_mux_1_in,
    input  logic [1:0]      select_mux_2_in,
    input  logic [1:0]      select_mux_4_in,
    input  logic [XLEN-1:0] reg_a_in,
    input  logic [XLEN-1:0] reg_b_in,
    input  logic [XLEN-1:0] immediate_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [6:0]      funct7e3_in,
    input  logic [2:0]      funct3_in,
    input  logic [4:0]      rd_in,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic [4:0]      rd_ex_mem,
    output logic            mem_re_out,
    output logic            mem_we_out,
    output logic            reg_file_write_out,
    output logic [1:0]      select_mux_4_out,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target
);

    typedef enum logic [1:0] {
        AluAdd    = 2'b00,
        AluBranch = 2'b01,
        AluRType  = 2'b10,
        AluIType  = 2'b11
    } alu_op_e;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      shamt;
    logic            alt_bit;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            br_lt_signed;
    logic            br_lt_unsigned;
    logic            br_equal;
    logic            br_cond;
    alu_op_e         alu_op;

    assign alu_op  = alu_op_e'(alu_op_in);
    assign alt_bit = funct7e3_in[5];

    always_comb begin
        unique case (select_mux_1_in)
            2'b00:   op_a = reg_a_in;
            2'b01:   op_a = pc_in;
            default: op_a = '0;
        endcase
    end

    always_comb begin
        unique case (select_mux_2_in)
            2'b00:   op_b = reg_b_in;
            2'b01:   op_b = immediate_in;
            default: op_b = XLEN'(4);
        endcase
    end

    assign shamt       = op_b[4:0];
    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;

    always_comb begin
        alu_result = '0;
        unique case (alu_op)
            AluAdd:    alu_result = op_a + op_b;
            AluBranch: alu_result = op_a - op_b;
            AluRType, AluIType: begin
                unique case (funct3_in)
                    // I-type has no subi: funct7 only matters for register-register add.
                    3'b000: alu_result = (alu_op == AluRType && alt_bit) ? op_a - op_b
                                                                         : op_a + op_b;
                    3'b001: alu_result = op_a << shamt;
                    3'b010: alu_result = {{(XLEN-1){1'b0}}, lt_signed};
                    3'b011: alu_result = {{(XLEN-1){1'b0}}, lt_unsigned};
                    3'b100: alu_result = op_a ^ op_b;
                    3'b101: alu_result = alt_bit ? XLEN'($signed(op_a) >>> shamt)
                                                 : op_a >> shamt;
                    3'b110: alu_result = op_a | op_b;
                    3'b111: alu_result = op_a & op_b;
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    // Branch compare always uses the raw register operands, not the muxed ALU inputs.
    assign br_equal       = reg_a_in == reg_b_in;
    assign br_lt_signed   = $signed(reg_a_in) < $signed(reg_b_in);
    assign br_lt_unsigned = reg_a_in < reg_b_in;

    always_comb begin
        br_cond = 1'b0;
        unique case (funct3_in)
            3'b000:  br_cond = br_equal;
            3'b001:  br_cond = !br_equal;
            3'b100:  br_cond = br_lt_signed;
            3'b101:  br_cond = !br_lt_signed;
            3'b110:  br_cond = br_lt_unsigned;
            3'b111:  br_cond = !br_lt_unsigned;
            default: br_cond = 1'b0;
        endcase
    end

    assign branch_taken  = branch_instruction_in & br_cond;
    assign branch_target = pc_in + immediate_in;

    // Bubbles are just zeroed controls, so the register loads unconditionally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_result_out     <= '0;
            store_data_out     <= '0;
            pc_plus4_out       <= '0;
            rd_ex_mem          <= '0;
            mem_re_out         <= 1'b0;
            mem_we_out         <= 1'b0;
            reg_file_write_out <= 1'b0;
            select_mux_4_out   <= '0;
        end else begin
            alu_result_out     <= alu_result;
            store_data_out     <= reg_b_in;
            pc_plus4_out       <= pc_in + XLEN'(4);
            rd_ex_mem          <= rd_in;
            mem_re_out         <= mem_re_in;
            mem_we_out         <= mem_we_in;
            reg_file_write_out <= reg_file_write_in;
            select_mux_4_out   <= select_mux_4_in;
        end
    end

endmodule

// File: tb/tb_instruction_execute.sv
// Randomized bench for instruction_execute against a behavioural model, plus literal checks.
module tb_instruction_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_re_in, mem_we_in, reg_file_write_in, branch_instruction_in;
    logic [1:0]  alu_op_in, select_mux_1_in, select_mux_2_in, select_mux_4_in;
    logic [31:0] reg_a_in, reg_b_in, immediate_in, pc_in;
    logic [6:0]  funct7e3_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_result_out, store_data_out, pc_plus4_out, branch_target;
    logic [4:0]  rd_ex_mem;
    logic        mem_re_out, mem_we_out, reg_file_write_out, branch_taken;
    logic [1:0]  select_mux_4_out;

    int total = 0;
    int bad   = 0;

    instruction_execute #(.XLEN(32)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .mem_re_in             (mem_re_in),
        .mem_we_in             (mem_we_in),
        .reg_file_write_in     (reg_file_write_in),
        .branch_instruction_in (branch_instruction_in),
        .alu_op_in             (alu_op_in),
        .select_mux_1_in       (select_mux_1_in),
        .select_mux_2_in       (select_mux_2_in),
        .select_mux_4_in       (select_mux_4_in),
        .reg_a_in              (reg_a_in),
        .reg_b_in              (reg_b_in),
        .immediate_in          (immediate_in),
        .pc_in                 (pc_in),
        .funct7e3_in           (funct7e3_in),
        .funct3_in             (funct3_in),
        .rd_in                 (rd_in),
        .alu_result_out        (alu_result_out),
        .store_data_out        (store_data_out),
        .pc_plus4_out          (pc_plus4_out),
        .rd_ex_mem             (rd_ex_mem),
        .mem_re_out            (mem_re_out),
        .mem_we_out            (mem_we_out),
        .reg_file_write_out    (reg_file_write_out),
        .select_mux_4_out      (select_mux_4_out),
        .branch_taken          (branch_taken),
        .branch_target         (branch_target)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model written from the instruction semantics using signed ints.
    function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [2:0] f3,
                                              input logic f7, input logic [1:0] s1,
                                              input logic [1:0] s2, input logic [31:0] ra,
                                              input logic [31:0] rb, input logic [31:0] imm,
                                              input logic [31:0] pc);
        logic [31:0] a, b;
        int          sa, sb;
        int unsigned sh;
        a  = (s1 == 2'd0) ? ra : (s1 == 2'd1) ? pc : 32'd0;
        b  = (s2 == 2'd0) ? rb : (s2 == 2'd1) ? imm : 32'd4;
        sa = int'(a);
        sb = int'(b);
        sh = int'(b) & 31;
        if (op == 2'd0) return a + b;
        if (op == 2'd1) return a - b;
        case (f3)
            3'd0: return (op == 2'd2 && f7) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 32'(sa >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic model_taken(input logic bi, input logic [2:0] f3,
                                         input logic [31:0] ra, input logic [31:0] rb);
        logic c;
        case (f3)
            3'd0: c = (ra == rb);
            3'd1: c = (ra != rb);
            3'd4: c = (int'(ra) < int'(rb));
            3'd5: c = (int'(ra) >= int'(rb));
            3'd6: c = (ra < rb);
            3'd7: c = (ra >= rb);
            default: c = 1'b0;
        endcase
        return bi && c;
    endfunction

    logic [31:0] e_alu, e_store, e_pc4;
    logic [4:0]  e_rd;
    logic        e_re, e_we, e_wr;
    logic [1:0]  e_sel4;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            e_alu <= 0; e_store <= 0; e_pc4 <= 0; e_rd <= 0;
            e_re <= 0; e_we <= 0; e_wr <= 0; e_sel4 <= 0;
        end else begin
            e_alu   <= model_alu(alu_op_in, funct3_in, funct7e3_in[5], select_mux_1_in,
                                 select_mux_2_in, reg_a_in, reg_b_in, immediate_in, pc_in);
            e_store <= reg_b_in;
            e_pc4   <= pc_in + 32'd4;
            e_rd    <= rd_in;
            e_re    <= mem_re_in;
            e_we    <= mem_we_in;
            e_wr    <= reg_file_write_in;
            e_sel4  <= select_mux_4_in;
        end
    end

    always @(negedge clock) begin
        chk("alu_result", alu_result_out, e_alu);
        chk("store_data", store_data_out, e_store);
        chk("pc_plus4", pc_plus4_out, e_pc4);
        chk("rd_ex_mem", 32'(rd_ex_mem), 32'(e_rd));
        chk("mem_re", 32'(mem_re_out), 32'(e_re));
        chk("mem_we", 32'(mem_we_out), 32'(e_we));
        chk("reg_write", 32'(reg_file_write_out), 32'(e_wr));
        chk("sel4", 32'(select_mux_4_out), 32'(e_sel4));
        chk("branch_taken", 32'(branch_taken),
            32'(model_taken(branch_instruction_in, funct3_in, reg_a_in, reg_b_in)));
        chk("branch_target", branch_target, pc_in + immediate_in);
    end

    task automatic idle();
        mem_re_in = 0; mem_we_in = 0; reg_file_write_in = 0; branch_instruction_in = 0;
        alu_op_in = 0; select_mux_1_in = 0; select_mux_2_in = 0; select_mux_4_in = 0;
        reg_a_in = 0; reg_b_in = 0; immediate_in = 0; pc_in = 0;
        funct7e3_in = 0; funct3_in = 0; rd_in = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic store_inputs();
        idle();
        alu_op_in = 2'b00; reg_a_in = 32'h100; immediate_in = 32'hFFFF_FFFC;
        select_mux_2_in = 2'b01; reg_b_in = 32'hDEAD; mem_we_in = 1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0: return $urandom();
            1: return 32'($urandom_range(0, 40));
            2: return 32'h8000_0000 | 32'($urandom_range(0, 3));
            default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
        endcase
    endfunction

    initial begin
        idle();
        reset    = 1'b0;
        reg_a_in = 32'h1234; reg_b_in = 32'h55; rd_in = 5'd9; mem_we_in = 1;
        reg_file_write_in = 1; pc_in = 32'h80;
        tick();
        chk("reset_alu", alu_result_out, 32'h0);
        chk("reset_rd", 32'(rd_ex_mem), 32'h0);
        chk("reset_we", 32'(mem_we_out), 32'h0);
        chk("reset_wr", 32'(reg_file_write_out), 32'h0);
        chk("reset_pc4", pc_plus4_out, 32'h0);
        #3 reset = 1'b1;

        tick();
        idle();
        reg_a_in = 32'd7; reg_b_in = 32'hFFFF_FFFD; alu_op_in = 2'b10; funct3_in = 3'b000;
        funct7e3_in = 7'b0100000; rd_in = 5'd5; reg_file_write_in = 1;
        tick();
        chk("rtype_sub", alu_result_out, 32'h0000_000A);
        chk("rtype_rd", 32'(rd_ex_mem), 32'd5);
        chk("rtype_wr", 32'(reg_file_write_out), 32'd1);

        idle();
        reg_a_in = 32'h8000_0000; immediate_in = 32'h0000_0404; alu_op_in = 2'b11;
        funct3_in = 3'b101; funct7e3_in = 7'b0100000; select_mux_2_in = 2'b01;
        tick();
        chk("srai", alu_result_out, 32'hF800_0000);
        funct7e3_in = 7'b0000000;
        tick();
        chk("srli", alu_result_out, 32'h0800_0000);

        idle();
        alu_op_in = 2'b00; reg_a_in = 32'h100; immediate_in = 32'hFFFF_FFFC;
        select_mux_2_in = 2'b01; mem_re_in = 1;
        tick();
        chk("load_addr", alu_result_out, 32'h0000_00FC);
        chk("load_re", 32'(mem_re_out), 32'd1);

        store_inputs();
        tick();
        chk("store_data", store_data_out, 32'h0000_DEAD);
        chk("store_we", 32'(mem_we_out), 32'd1);
        idle();
        tick();
        chk("bubble_we", 32'(mem_we_out), 32'd0);
        chk("bubble_wr", 32'(reg_file_write_out), 32'd0);

        idle();
        pc_in = 32'h40; immediate_in = 32'hFFFF_FFF0; reg_a_in = 32'hFFFF_FFFF;
        reg_b_in = 32'd1; branch_instruction_in = 1; alu_op_in = 2'b01; funct3_in = 3'b100;
        #1;
        chk("blt_taken", 32'(branch_taken), 32'd1);
        chk("blt_target", branch_target, 32'h30);
        funct3_in = 3'b110;
        #1 chk("bltu_not", 32'(branch_taken), 32'd0);
        funct3_in = 3'b000; reg_b_in = 32'hFFFF_FFFF;
        #1 chk("beq_taken", 32'(branch_taken), 32'd1);
        branch_instruction_in = 0;
        #1 chk("nobranch", 32'(branch_taken), 32'd0);

        store_inputs();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async_we", 32'(mem_we_out), 32'd0);
        chk("async_store", store_data_out, 32'd0);
        chk("async_alu", alu_result_out, 32'd0);
        #3 reset = 1'b1;
        #1 chk("held_we", 32'(mem_we_out), 32'd0);
        tick();
        chk("release_store", store_data_out, 32'h0000_DEAD);
        chk("release_we", 32'(mem_we_out), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            mem_re_in             = 1'($urandom());
            mem_we_in             = 1'($urandom());
            reg_file_write_in     = 1'($urandom());
            branch_instruction_in = 1'($urandom());
            alu_op_in             = 2'($urandom());
            select_mux_1_in       = 2'($urandom());
            select_mux_2_in       = 2'($urandom());
            select_mux_4_in       = 2'($urandom());
            reg_a_in              = rand_word();
            reg_b_in              = ($urandom_range(0, 5) == 0) ? reg_a_in : rand_word();
            immediate_in          = rand_word();
            pc_in                 = $urandom() & 32'hFFFF_FFFC;
            funct7e3_in           = 7'($urandom());
            funct3_in             = 3'($urandom());
            rd_in                 = 5'($urandom());
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick();
        end

        idle();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
